// File: rtl/rssb_ctrl.sv
// Purpose: single-instruction (reverse-subtract-and-skip-if-borrow) CPU controller.
// Latency: 3 cycles per instruction (FETCH, EXEC, WRITE); memory read is combinational.
// Backpressure: none; start is ignored while busy or halted, only rst leaves HALT.
module rssb_ctrl #(
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] RESET_PC = {1'b1, {(WIDTH-1){1'b0}}},
    parameter logic [WIDTH-1:0] HALT_OP  = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic             mem_write,
    output logic             busy,
    output logic             halted,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] acc
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_EXEC  = 3'd2;
    localparam logic [2:0] ST_WRITE = 3'd3;
    localparam logic [2:0] ST_HALT  = 3'd4;

    logic [2:0]       state;
    logic [WIDTH-1:0] ir;
    logic             borrow;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] pc_step;

    assign diff    = mem_rdata - acc;
    assign pc_step = borrow ? WIDTH'(2) : WIDTH'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            pc     <= RESET_PC;
            acc    <= '0;
            ir     <= '0;
            borrow <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) state <= ST_FETCH;
                end
                ST_FETCH: begin
                    if (mem_rdata == HALT_OP) begin
                        state <= ST_HALT;
                    end else begin
                        ir    <= mem_rdata;
                        state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    acc    <= diff;
                    borrow <= (mem_rdata < acc);
                    state  <= ST_WRITE;
                end
                ST_WRITE: begin
                    pc    <= pc + pc_step;
                    state <= ST_FETCH;
                end
                ST_HALT: state <= ST_HALT;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // The write strobe is masked by rst so a reset landing on WRITE never commits to memory.
    always_comb begin
        mem_addr  = pc;
        mem_wdata = '0;
        mem_write = 1'b0;
        case (state)
            ST_EXEC:  mem_addr = ir;
            ST_WRITE: begin
                mem_addr  = ir;
                mem_wdata = acc;
                mem_write = ~ir[WIDTH-1] & ~rst;
            end
            default: ;
        endcase
    end

    assign busy   = (state == ST_FETCH) || (state == ST_EXEC) || (state == ST_WRITE);
    assign halted = (state == ST_HALT);

endmodule

// File: tb/tb_rssb_ctrl.sv
// Bench for rssb_ctrl: directed programs plus a randomized program checked against an instruction-level model.
module tb_rssb_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] mem_rdata, mem_addr, mem_wdata, pc, acc;
    logic       mem_write, busy, halted;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] mem [256];
    logic [7:0] img [256];
    logic       load_req = 1'b0;

    rssb_ctrl #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .mem_rdata(mem_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write),
        .busy(busy), .halted(halted), .pc(pc), .acc(acc)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (load_req) mem = img;
        else if (mem_write) mem[mem_addr] = mem_wdata;
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic clear_img();
        for (int i = 0; i < 256; i++) img[i] = 8'h00;
    endtask

    // Holds reset while the image is copied into memory; returns at a negedge with DUT idle.
    task automatic load_and_reset();
        rst = 1'b1; start = 1'b0; load_req = 1'b1;
        cyc();
        load_req = 1'b0;
        cyc();
        rst = 1'b0;
        cyc();
    endtask

    task automatic kick();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic test_reset();
        clear_img();
        rst = 1'b1; load_req = 1'b1;
        cyc();
        load_req = 1'b0;
        cyc();
        n_cmp++; if (pc !== 8'h80) begin n_bad++; $display("FAIL reset_pc got=%h exp=80", pc); end
        n_cmp++; if (acc !== 8'h00) begin n_bad++; $display("FAIL reset_acc got=%h exp=00", acc); end
        n_cmp++; if (busy !== 1'b0 || halted !== 1'b0) begin n_bad++; $display("FAIL reset_flags busy=%b halted=%b exp=0/0", busy, halted); end
        n_cmp++; if (mem_write !== 1'b0 || mem_addr !== 8'h80 || mem_wdata !== 8'h00) begin n_bad++; $display("FAIL reset_bus we=%b addr=%h wd=%h exp=0/80/00", mem_write, mem_addr, mem_wdata); end
        rst = 1'b0;
        cyc(); cyc();
        n_cmp++; if (busy !== 1'b0 || pc !== 8'h80) begin n_bad++; $display("FAIL idle_hold busy=%b pc=%h exp=0/80", busy, pc); end
    endtask

    task automatic test_basic();
        clear_img();
        img[8'h80] = 8'h10; img[8'h10] = 8'h05;
        img[8'h81] = 8'h11; img[8'h11] = 8'h03; img[8'h83] = 8'hFF;
        load_and_reset();
        kick();
        n_cmp++; if (busy !== 1'b1 || mem_addr !== 8'h80 || mem_write !== 1'b0) begin n_bad++; $display("FAIL basic_fetch busy=%b addr=%h we=%b exp=1/80/0", busy, mem_addr, mem_write); end
        cyc();
        n_cmp++; if (mem_addr !== 8'h10 || mem_write !== 1'b0) begin n_bad++; $display("FAIL basic_exec addr=%h we=%b exp=10/0", mem_addr, mem_write); end
        cyc();
        n_cmp++; if (acc !== 8'h05) begin n_bad++; $display("FAIL basic_acc got=%h exp=05", acc); end
        n_cmp++; if (mem_write !== 1'b1 || mem_addr !== 8'h10 || mem_wdata !== 8'h05) begin n_bad++; $display("FAIL basic_write we=%b addr=%h wd=%h exp=1/10/05", mem_write, mem_addr, mem_wdata); end
        cyc();
        n_cmp++; if (pc !== 8'h81 || mem_addr !== 8'h81 || busy !== 1'b1) begin n_bad++; $display("FAIL basic_next_fetch pc=%h addr=%h busy=%b exp=81/81/1", pc, mem_addr, busy); end
        n_cmp++; if (mem[8'h10] !== 8'h05) begin n_bad++; $display("FAIL basic_ram got=%h exp=05", mem[8'h10]); end
    endtask

    task automatic test_borrow();
        cyc(); cyc();
        n_cmp++; if (acc !== 8'hFE) begin n_bad++; $display("FAIL borrow_acc got=%h exp=FE", acc); end
        n_cmp++; if (mem_write !== 1'b1 || mem_addr !== 8'h11 || mem_wdata !== 8'hFE) begin n_bad++; $display("FAIL borrow_write we=%b addr=%h wd=%h exp=1/11/FE", mem_write, mem_addr, mem_wdata); end
        cyc();
        n_cmp++; if (pc !== 8'h83) begin n_bad++; $display("FAIL borrow_pc got=%h exp=83", pc); end
        n_cmp++; if (mem[8'h11] !== 8'hFE) begin n_bad++; $display("FAIL borrow_ram got=%h exp=FE", mem[8'h11]); end
    endtask

    task automatic test_rom_operand();
        int wr_seen;
        clear_img();
        img[8'h80] = 8'hA0; img[8'hA0] = 8'h01;
        img[8'h81] = 8'hA1; img[8'hA1] = 8'h02;
        img[8'h82] = 8'hA1;
        img[8'h83] = 8'h90; img[8'h90] = 8'h04;
        img[8'h84] = 8'hFF;
        load_and_reset();
        kick();
        repeat (9) cyc();
        n_cmp++; if (pc !== 8'h83 || acc !== 8'h01) begin n_bad++; $display("FAIL rom_setup pc=%h acc=%h exp=83/01", pc, acc); end
        wr_seen = 0;
        repeat (2) begin
            cyc();
            if (mem_write !== 1'b0) wr_seen++;
        end
        n_cmp++; if (wr_seen != 0) begin n_bad++; $display("FAIL rom_no_write strobes=%0d exp=0", wr_seen); end
        n_cmp++; if (acc !== 8'h03) begin n_bad++; $display("FAIL rom_acc got=%h exp=03", acc); end
        cyc();
        n_cmp++; if (pc !== 8'h84 || mem[8'h90] !== 8'h04) begin n_bad++; $display("FAIL rom_pc pc=%h rom90=%h exp=84/04", pc, mem[8'h90]); end
    endtask

    task automatic test_halt();
        cyc();
        n_cmp++; if (halted !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL halt_flags halted=%b busy=%b exp=1/0", halted, busy); end
        n_cmp++; if (mem_addr !== 8'h84 || mem_wdata !== 8'h00 || mem_write !== 1'b0) begin n_bad++; $display("FAIL halt_bus addr=%h wd=%h we=%b exp=84/00/0", mem_addr, mem_wdata, mem_write); end
        kick();
        repeat (3) cyc();
        n_cmp++; if (pc !== 8'h84 || acc !== 8'h03 || halted !== 1'b1) begin n_bad++; $display("FAIL halt_hold pc=%h acc=%h halted=%b exp=84/03/1", pc, acc, halted); end
    endtask

    task automatic test_reset_in_write();
        clear_img();
        img[8'h80] = 8'h20; img[8'h20] = 8'h07; img[8'h81] = 8'hFF;
        load_and_reset();
        kick();
        cyc(); cyc();
        n_cmp++; if (mem_write !== 1'b1) begin n_bad++; $display("FAIL rstw_pre we=%b exp=1", mem_write); end
        rst = 1'b1;
        #1;
        n_cmp++; if (mem_write !== 1'b0) begin n_bad++; $display("FAIL rstw_gate we=%b exp=0", mem_write); end
        cyc();
        n_cmp++; if (pc !== 8'h80 || acc !== 8'h00 || busy !== 1'b0 || halted !== 1'b0) begin n_bad++; $display("FAIL rstw_state pc=%h acc=%h busy=%b halted=%b exp=80/00/0/0", pc, acc, busy, halted); end
        n_cmp++; if (mem[8'h20] !== 8'h07) begin n_bad++; $display("FAIL rstw_ram got=%h exp=07", mem[8'h20]); end
        rst = 1'b0;
        cyc(); cyc();
        n_cmp++; if (busy !== 1'b0 || mem_addr !== 8'h80) begin n_bad++; $display("FAIL rstw_idle busy=%b addr=%h exp=0/80", busy, mem_addr); end
    endtask

    // 127 instructions at 80..FE alternate acc between A5 and 00 without skipping; FF then borrows.
    task automatic test_wrap();
        clear_img();
        for (int i = 8'h80; i < 8'hFF; i++) img[i] = 8'hA5;
        img[8'hFF] = 8'h00; img[8'h00] = 8'h00; img[8'h01] = 8'hFF;
        load_and_reset();
        kick();
        repeat (127 * 3) cyc();
        n_cmp++; if (pc !== 8'hFF || acc !== 8'hA5) begin n_bad++; $display("FAIL wrap_pre pc=%h acc=%h exp=FF/A5", pc, acc); end
        repeat (3) cyc();
        n_cmp++; if (pc !== 8'h01) begin n_bad++; $display("FAIL wrap_pc got=%h exp=01", pc); end
        n_cmp++; if (acc !== 8'h5B || mem[8'h00] !== 8'h5B) begin n_bad++; $display("FAIL wrap_acc acc=%h ram00=%h exp=5B/5B", acc, mem[8'h00]); end
        cyc();
        n_cmp++; if (halted !== 1'b1) begin n_bad++; $display("FAIL wrap_halt got=%b exp=1", halted); end
    endtask

    task automatic test_random();
        logic [7:0] rm [256];
        logic [7:0] rpc, racc, ir, v, nd;
        logic       skip;
        int         bad_ram;
        for (int i = 0; i < 128; i++) img[i] = 8'($urandom);
        for (int i = 128; i < 256; i++) img[i] = 8'($urandom_range(0, 254));
        load_and_reset();
        rm = img;
        rpc = 8'h80; racc = 8'h00;
        kick();
        for (int n = 0; n < 30; n++) begin
            n_cmp++; if (pc !== rpc || acc !== racc || busy !== 1'b1 || mem_addr !== rpc) begin n_bad++; $display("FAIL rand_fetch[%0d] pc=%h acc=%h busy=%b addr=%h exp=%h/%h/1/%h", n, pc, acc, busy, mem_addr, rpc, racc, rpc); end
            ir = rm[rpc];
            v = rm[ir];
            nd = v - racc;
            skip = (v < racc);
            start = 1'($urandom);
            cyc();
            n_cmp++; if (mem_addr !== ir || mem_write !== 1'b0) begin n_bad++; $display("FAIL rand_exec[%0d] addr=%h we=%b exp=%h/0", n, mem_addr, mem_write, ir); end
            start = 1'($urandom);
            cyc();
            n_cmp++; if (mem_write !== (ir < 8'h80) || mem_addr !== ir || mem_wdata !== nd || acc !== nd) begin n_bad++; $display("FAIL rand_write[%0d] we=%b addr=%h wd=%h acc=%h exp=%b/%h/%h/%h", n, mem_write, mem_addr, mem_wdata, acc, (ir < 8'h80), ir, nd, nd); end
            if (ir < 8'h80) rm[ir] = nd;
            racc = nd;
            rpc = rpc + (skip ? 8'd2 : 8'd1);
            start = 1'($urandom);
            cyc();
        end
        start = 1'b0;
        bad_ram = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== rm[i]) bad_ram++;
        n_cmp++; if (bad_ram != 0) begin n_bad++; $display("FAIL rand_memory differing_bytes=%0d exp=0", bad_ram); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_borrow();
        test_rom_operand();
        test_halt();
        test_reset_in_write();
        test_wrap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
